// File: rtl/tm_mem_arbiter.sv
// tm_mem_arbiter: shares one single-port program/tape memory (1-cycle
// synchronous read) among three requesters. One access is issued per cycle.
// A requester may hold ownership across cycles by asserting lock, but only
// for a bounded number of cycles. This lets the compute sequencer do an
// atomic read-modify-write.
//
// Build option: define TM_ARB_ROUND_ROBIN_EN to make requesters 1 and 2
// alternate. When it is not defined, the priority is fixed at 0 > 1 > 2.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   req/lock/we [2:0]   per-requester request, lock-hold and write flags
//   addrN, wdataN       per-requester address and write data
//   gnt [2:0]           one-hot grant (combinational, same cycle)
//   rvalid [2:0]        one-hot read return, one cycle after a granted read
//   rdata               read data, qualified by rvalid (zero otherwise)
//   lock_abort          pulse in the cycle a lock is forcibly ended
//   mem_re/we/addr/wdata/rdata  memory interface
module tm_mem_arbiter #(
  parameter int unsigned DW       = 4,
  parameter int unsigned W        = 64,
  parameter int unsigned AW       = $clog2(W),
  parameter int unsigned LOCK_MAX = 15
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [2:0]    req,
  input  logic [2:0]    lock,
  input  logic [2:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic [DW-1:0] wdata2,
  output logic [2:0]    gnt,
  output logic [2:0]    rvalid,
  output logic [DW-1:0] rdata,
  output logic          lock_abort,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] LOCK_LIM = CW'(LOCK_MAX);

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [2:0]    owner_q, owner_d;   // one-hot lock owner
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0]    rvalid_q, rvalid_d;
  logic [2:0]    win_oh;

`ifdef TM_ARB_ROUND_ROBIN_EN
  logic       ptr2_q, ptr2_d;        // 1: requester 2 wins a 1-vs-2 tie
  logic [1:0] rel12;                 // requester 1/2 finishing ownership
`endif

  // IDLE arbitration winner
  always_comb begin
    win_oh = '0;
    if (req[0]) begin
      win_oh = 3'b001;
`ifdef TM_ARB_ROUND_ROBIN_EN
    end else if (req[1] && req[2]) begin
      win_oh = ptr2_q ? 3'b100 : 3'b010;
`endif
    end else if (req[1]) begin
      win_oh = 3'b010;
    end else if (req[2]) begin
      win_oh = 3'b100;
    end
  end

  // Next state, grant and abort
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    gnt        = '0;
    lock_abort = 1'b0;
    cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    case (state_q)
      ST_IDLE: begin
        gnt = win_oh;
        if (|(win_oh & lock)) begin
          // A one-cycle budget is used up by this grant.
          if (CW'(1) >= LOCK_LIM) begin
            lock_abort = 1'b1;
          end else begin
            state_d = ST_LOCKED;
            owner_d = win_oh;
            cnt_d   = CW'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (|(req & owner_q)) begin
          gnt   = owner_q;
          cnt_d = cnt_inc;
          if (!(|(lock & owner_q)) || (cnt_inc >= LOCK_LIM)) begin
            lock_abort = |(lock & owner_q);
            state_d    = ST_IDLE;
            owner_d    = '0;
            cnt_d      = '0;
          end
        end else begin
          // The owner withdrew, so nothing is granted this cycle.
          state_d = ST_IDLE;
          owner_d = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = '0;
        cnt_d   = '0;
      end
    endcase
    // Keep every combinational output quiet while reset is asserted.
    if (!reset) begin
      gnt        = '0;
      lock_abort = 1'b0;
    end
  end

`ifdef TM_ARB_ROUND_ROBIN_EN
  // The pointer moves away from requester 1 or 2 once its ownership ends.
  always_comb begin
    rel12 = '0;
    if (state_d == ST_IDLE) begin
      rel12 = (state_q == ST_IDLE) ? win_oh[2:1] : owner_q[2:1];
    end
    ptr2_d = ptr2_q;
    if (rel12[0]) begin
      ptr2_d = 1'b1;
    end else if (rel12[1]) begin
      ptr2_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ptr2_q <= 1'b0;
    else        ptr2_q <= ptr2_d;
  end
`endif

  // Memory request mux
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[0]) begin
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt[1]) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end else if (gnt[2]) begin
      mem_addr  = addr2;
      mem_wdata = wdata2;
    end
  end

  assign mem_re   = |(gnt & ~we);
  assign mem_we   = |(gnt & we);
  assign rvalid_d = gnt & ~we;
  assign rvalid   = rvalid_q;
  // The memory's output register is the pipeline stage, so its data is
  // passed through only in the cycle it belongs to a requester.
  assign rdata    = (|rvalid_q) ? mem_rdata : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      cnt_q    <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

endmodule
